// File: rtl/hall_speed_meter.sv
// Multi-channel Hall-sensor speed meter: debounced rising edges per channel are counted over a
// fixed gate window and published with overflow and stall status at each window close.
module hall_speed_meter #(
  parameter int unsigned CH        = 2,
  parameter int unsigned CNT_W     = 10,
  parameter int unsigned GATE_CYC  = 50000000,
  parameter int unsigned DEB_CYC   = 1000,
  parameter int unsigned STALL_WIN = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [CH-1:0]       hall_in,
  output logic [CH*CNT_W-1:0] speed,
  output logic                speed_valid,
  output logic                dig_show,
  output logic [CH-1:0]       ovf,
  output logic [CH-1:0]       stall
);

  localparam int unsigned GateW  = $clog2(GATE_CYC);
  localparam int unsigned DebW   = $clog2(DEB_CYC + 1);
  localparam int unsigned StallW = $clog2(STALL_WIN + 1);

  // Input path state (runs regardless of enable)
  logic [CH-1:0]           sync1_q, sync2_q;
  logic [CH-1:0]           filt_q, filt_d, filt_prev_q;
  logic [CH-1:0][DebW-1:0] deb_cnt_q, deb_cnt_d;
  logic [CH-1:0]           edge_pulse;

  // Measurement state
  logic [GateW-1:0]          gate_q, gate_d;
  logic                      terminal;
  logic [CH-1:0][CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic [CH-1:0]             sat_q, sat_d;
  logic [CH-1:0][StallW-1:0] zero_q, zero_d;
  logic [CH-1:0][CNT_W-1:0]  speed_q, speed_d;
  logic [CH-1:0]             ovf_q, ovf_d;
  logic [CH-1:0]             stall_q, stall_d;
  logic                      valid_q, valid_d;
  logic                      show_q, show_d;

  logic [CH-1:0][CNT_W-1:0]  cnt_inc;
  logic [CH-1:0]             sat_inc;
  logic [CH-1:0][StallW-1:0] zero_nxt;

  assign edge_pulse = filt_q & ~filt_prev_q;

  // Filtered value flips on the DEB_CYC-th consecutive disagreeing sample
  always_comb begin
    filt_d    = filt_q;
    deb_cnt_d = '0;
    for (int i = 0; i < CH; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (deb_cnt_q[i] == DebW'(DEB_CYC - 1)) begin
          filt_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign terminal = enable && (gate_q == GateW'(GATE_CYC - 1));

  always_comb begin
    gate_d     = '0;
    edge_cnt_d = '0;
    sat_d      = '0;
    zero_d     = '0;
    speed_d    = '0;
    ovf_d      = '0;
    stall_d    = '0;
    valid_d    = 1'b0;
    show_d     = 1'b0;
    cnt_inc    = '0;
    sat_inc    = '0;
    zero_nxt   = '0;
    for (int i = 0; i < CH; i++) begin
      cnt_inc[i] = edge_cnt_q[i] + CNT_W'(edge_pulse[i] && (edge_cnt_q[i] != '1));
      sat_inc[i] = sat_q[i] | (edge_pulse[i] && (edge_cnt_q[i] == '1));
      if (cnt_inc[i] == '0) begin
        zero_nxt[i] = (zero_q[i] == StallW'(STALL_WIN)) ? zero_q[i] : zero_q[i] + 1'b1;
      end
    end
    if (enable) begin
      gate_d  = terminal ? '0 : gate_q + 1'b1;
      speed_d = speed_q;
      ovf_d   = ovf_q;
      stall_d = stall_q;
      zero_d  = zero_q;
      show_d  = show_q;
      if (terminal) begin
        valid_d = 1'b1;
        show_d  = 1'b1;
        for (int i = 0; i < CH; i++) begin
          speed_d[i] = cnt_inc[i];
          ovf_d[i]   = sat_inc[i];
          zero_d[i]  = zero_nxt[i];
          stall_d[i] = (zero_nxt[i] == StallW'(STALL_WIN));
        end
      end else begin
        edge_cnt_d = cnt_inc;
        sat_d      = sat_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      filt_q      <= '0;
      filt_prev_q <= '0;
      deb_cnt_q   <= '0;
      gate_q      <= '0;
      edge_cnt_q  <= '0;
      sat_q       <= '0;
      zero_q      <= '0;
      speed_q     <= '0;
      ovf_q       <= '0;
      stall_q     <= '0;
      valid_q     <= 1'b0;
      show_q      <= 1'b0;
    end else begin
      sync1_q     <= hall_in;
      sync2_q     <= sync1_q;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      deb_cnt_q   <= deb_cnt_d;
      gate_q      <= gate_d;
      edge_cnt_q  <= edge_cnt_d;
      sat_q       <= sat_d;
      zero_q      <= zero_d;
      speed_q     <= speed_d;
      ovf_q       <= ovf_d;
      stall_q     <= stall_d;
      valid_q     <= valid_d;
      show_q      <= show_d;
    end
  end

  assign speed       = speed_q;
  assign speed_valid = valid_q;
  assign dig_show    = show_q;
  assign ovf         = ovf_q;
  assign stall       = stall_q;

endmodule

// File: tb/tb_hall_speed_meter.sv
// Directed bench for hall_speed_meter: expected window results are queued as stimulus is
// driven and compared whenever speed_valid pulses.
module tb_hall_speed_meter;

  localparam int unsigned CH = 2;
  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic [3:0] s0;
    logic [3:0] s1;
    logic [1:0] ovf;
    logic [1:0] stall;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                enable = 1'b0;
  logic                en_sat = 1'b0;
  logic [CH-1:0]       hall = '0;
  logic [CH*CNT_W-1:0] speed, speed_s;
  logic                speed_valid, speed_valid_s;
  logic                dig_show, dig_show_s;
  logic [CH-1:0]       ovf, ovf_s, stall, stall_s;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  exp_t exp_sat_q[$];

  always #5 clk = ~clk;

  hall_speed_meter #(
    .CH(CH), .CNT_W(CNT_W), .GATE_CYC(100), .DEB_CYC(4), .STALL_WIN(2)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .hall_in(hall), .speed(speed),
    .speed_valid(speed_valid), .dig_show(dig_show), .ovf(ovf), .stall(stall)
  );

  // Longer window so 20 debounced pulses fit and saturate the 4-bit count
  hall_speed_meter #(
    .CH(CH), .CNT_W(CNT_W), .GATE_CYC(200), .DEB_CYC(4), .STALL_WIN(2)
  ) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .enable(en_sat), .hall_in(hall), .speed(speed_s),
    .speed_valid(speed_valid_s), .dig_show(dig_show_s), .ovf(ovf_s), .stall(stall_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input int s0, input int s1, input logic [1:0] o,
                              input logic [1:0] st);
    exp_t e;
    e.s0 = 4'(s0);
    e.s1 = 4'(s1);
    e.ovf = o;
    e.stall = st;
    return e;
  endfunction

  task automatic compare(input string pfx, input exp_t e, input logic [7:0] sp,
                         input logic [1:0] o, input logic [1:0] st);
    check({pfx, "_speed0"}, 32'(sp[3:0]), 32'(e.s0));
    check({pfx, "_speed1"}, 32'(sp[7:4]), 32'(e.s1));
    check({pfx, "_ovf"}, 32'(o), 32'(e.ovf));
    check({pfx, "_stall"}, 32'(st), 32'(e.stall));
  endtask

  always @(negedge clk) begin
    if (speed_valid) begin
      if (exp_q.size() == 0) begin
        check("main_unexpected_valid", 32'(speed_valid), 32'd0);
      end else begin
        compare("main", exp_q.pop_front(), speed, ovf, stall);
      end
    end
    if (speed_valid_s) begin
      if (exp_sat_q.size() == 0) begin
        check("sat_unexpected_valid", 32'(speed_valid_s), 32'd0);
      end else begin
        compare("sat", exp_sat_q.pop_front(), speed_s, ovf_s, stall_s);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic pulse(input int ch, input int hi, input int lo);
    hall[ch] = 1'b1;
    repeat (hi) tick();
    hall[ch] = 1'b0;
    repeat (lo) tick();
  endtask

  // Walks to the close of a 100-cycle window and one cycle past it
  task automatic close_window(input string tag);
    wait_to(99);
    check({tag, "_valid_before"}, 32'(speed_valid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(speed_valid), 32'd1);
    check({tag, "_dig_show"}, 32'(dig_show), 32'd1);
    cyc = 0;
    tick();
    check({tag, "_valid_after"}, 32'(speed_valid), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_speed", 32'(speed), 32'd0);
    check("rst_valid", 32'(speed_valid), 32'd0);
    check("rst_dig_show", 32'(dig_show), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();

    // 1: five clean pulses on ch0
    enable = 1'b1;
    cyc = 0;
    exp_q.push_back(mk(5, 0, 2'b00, 2'b00));
    repeat (4) pulse(0, 10, 10);
    pulse(0, 10, 0);
    close_window("w1");

    // 2: 3-cycle glitches rejected, then two clean pulses; ch1 second idle window
    exp_q.push_back(mk(2, 0, 2'b00, 2'b10));
    repeat (6) pulse(0, 3, 5);
    repeat (2) pulse(0, 10, 10);
    close_window("w2");

    // 4: one ch1 pulse clears stall; ch0 starts its own idle run
    exp_q.push_back(mk(0, 1, 2'b00, 2'b00));
    pulse(1, 10, 10);
    close_window("w3");
    exp_q.push_back(mk(0, 0, 2'b00, 2'b01));
    close_window("w4");
    exp_q.push_back(mk(0, 0, 2'b00, 2'b11));
    close_window("w5");

    // 6: edge pulse on the terminal cycle counts now; one cycle later counts next window
    exp_q.push_back(mk(1, 0, 2'b00, 2'b10));
    wait_to(93);
    hall[0] = 1'b1;
    tick();
    hall[1] = 1'b1;
    close_window("w6");
    exp_q.push_back(mk(0, 1, 2'b00, 2'b00));
    wait_to(5);
    hall = '0;
    close_window("w7");

    // 5: drop enable mid-window after three edges
    repeat (2) pulse(0, 10, 10);
    hall[0] = 1'b1;
    wait_to(50);
    enable = 1'b0;
    tick();
    hall[0] = 1'b0;
    check("dis_speed", 32'(speed), 32'd0);
    check("dis_dig_show", 32'(dig_show), 32'd0);
    check("dis_valid", 32'(speed_valid), 32'd0);
    check("dis_stall", 32'(stall), 32'd0);
    repeat (3) pulse(0, 10, 10);
    repeat (30) tick();
    enable = 1'b1;
    cyc = 0;
    exp_q.push_back(mk(2, 0, 2'b00, 2'b00));
    repeat (2) pulse(0, 10, 10);
    wait_to(98);
    check("reen_dig_show_low", 32'(dig_show), 32'd0);
    close_window("w8");

    // 6: synchronous reset mid-window
    pulse(0, 10, 10);
    wait_to(60);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mrst_speed", 32'(speed), 32'd0);
    check("mrst_dig_show", 32'(dig_show), 32'd0);
    check("mrst_valid", 32'(speed_valid), 32'd0);
    check("mrst_ovf", 32'(ovf), 32'd0);
    check("mrst_stall", 32'(stall), 32'd0);
    cyc = 0;
    exp_q.push_back(mk(1, 0, 2'b00, 2'b00));
    pulse(0, 10, 10);
    close_window("w10");
    enable = 1'b0;
    repeat (5) tick();

    // 3: saturation on the 200-cycle instance
    en_sat = 1'b1;
    cyc = 0;
    exp_sat_q.push_back(mk(15, 0, 2'b01, 2'b00));
    repeat (20) pulse(0, 4, 4);
    wait_to(199);
    check("sat_valid_before", 32'(speed_valid_s), 32'd0);
    tick();
    check("sat_valid", 32'(speed_valid_s), 32'd1);
    cyc = 0;
    exp_sat_q.push_back(mk(1, 0, 2'b00, 2'b10));
    pulse(0, 10, 10);
    wait_to(200);
    check("sat2_valid", 32'(speed_valid_s), 32'd1);
    en_sat = 1'b0;
    repeat (5) tick();

    check("main_queue_drained", 32'(exp_q.size()), 32'd0);
    check("sat_queue_drained", 32'(exp_sat_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
